// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC multiplexed address/data bus engine:
// the phase encoding, strobe levels and the w_r direction codes.
package rtc_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StAddr = 3'd1,
        StGap1 = 3'd2,
        StData = 3'd3,
        StGap2 = 3'd4,
        StDone = 3'd5
    } rtc_state_e;

    // RTC strobes are active-low
    localparam logic STROBE_IDLE   = 1'b1;
    localparam logic STROBE_ACTIVE = 1'b0;

    localparam logic W_R_WRITE = 1'b1;
    localparam logic W_R_READ  = 1'b0;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter with a zero flag; one instance times every phase of a bus access.
module rtc_phase_timer #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/rtc_ad_bus_ctrl.sv
// Bus-cycle engine for the RTC multiplexed AD port: ADDR, GAP1, DATA, GAP2, DONE per access.
// Define RTC_AD_SYNC_EN to pass ad_in through a 2-flop synchronizer before read capture.
module rtc_ad_bus_ctrl #(
    parameter int unsigned T_ADDR = 10,
    parameter int unsigned T_GAP  = 10,
    parameter int unsigned T_DATA = 10,
    parameter int unsigned CNT_W  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       do_it,
    input  logic       w_r,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic       a_d,
    output logic       send_add,
    output logic       send_data,
    output logic       read_data,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done
);

    import rtc_pkg::*;

    localparam logic [CNT_W-1:0] LD_ADDR = CNT_W'(T_ADDR - 1);
    localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] LD_DATA = CNT_W'(T_DATA - 1);

    rtc_state_e       state_q, state_d;
    logic             do_it_q;
    logic             start;
    logic             w_r_q;
    logic [7:0]       addr_q, wdata_q, rdata_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             capture;
    logic [7:0]       cap_val;

    rtc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign start = (state_q == StIdle) & do_it & ~do_it_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            do_it_q <= 1'b0;
        end else begin
            state_q <= state_d;
            do_it_q <= do_it;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_r_q   <= W_R_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start) begin
            w_r_q   <= w_r;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            StIdle: if (start) begin
                state_d  = StAddr;
                tmr_load = 1'b1;
                tmr_val  = LD_ADDR;
            end
            StAddr: if (tmr_zero) begin
                state_d  = StGap1;
                tmr_load = 1'b1;
                tmr_val  = LD_GAP;
            end
            StGap1: if (tmr_zero) begin
                state_d  = StData;
                tmr_load = 1'b1;
                tmr_val  = LD_DATA;
            end
            StData: if (tmr_zero) begin
                state_d  = StGap2;
                tmr_load = 1'b1;
                tmr_val  = LD_GAP;
            end
            StGap2: if (tmr_zero) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cs        = STROBE_IDLE;
        rd        = STROBE_IDLE;
        wr        = STROBE_IDLE;
        a_d       = 1'b1;
        ad_oe     = 1'b0;
        ad_out    = '0;
        send_add  = 1'b0;
        send_data = 1'b0;
        read_data = 1'b0;
        done      = 1'b0;
        case (state_q)
            StAddr: begin
                cs       = STROBE_ACTIVE;
                wr       = STROBE_ACTIVE;
                a_d      = 1'b0;
                ad_oe    = 1'b1;
                ad_out   = addr_q;
                send_add = 1'b1;
            end
            StGap1: begin
                // A read releases the bus one cycle early so ad_oe never moves with rd falling
                ad_oe  = (w_r_q == W_R_WRITE) | ~tmr_zero;
                ad_out = addr_q;
            end
            StData: begin
                cs = STROBE_ACTIVE;
                if (w_r_q == W_R_WRITE) begin
                    wr        = STROBE_ACTIVE;
                    ad_oe     = 1'b1;
                    ad_out    = wdata_q;
                    send_data = 1'b1;
                end else begin
                    rd        = STROBE_ACTIVE;
                    read_data = 1'b1;
                end
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state_q != StIdle) | start;

`ifdef RTC_AD_SYNC_EN
    logic [7:0] ad_s1_q, ad_s2_q;
    logic       cap_p1_q, cap_p2_q;

    // The strobe trails the last DATA cycle by two flops, matching the synchronizer depth
    always_ff @(posedge clk) begin
        if (reset) begin
            ad_s1_q  <= '0;
            ad_s2_q  <= '0;
            cap_p1_q <= 1'b0;
            cap_p2_q <= 1'b0;
        end else begin
            ad_s1_q  <= ad_in;
            ad_s2_q  <= ad_s1_q;
            cap_p1_q <= (state_q == StData) & tmr_zero & (w_r_q == W_R_READ);
            cap_p2_q <= cap_p1_q;
        end
    end

    assign capture = cap_p2_q;
    assign cap_val = ad_s2_q;
`else
    assign capture = (state_q == StData) & tmr_zero & (w_r_q == W_R_READ);
    assign cap_val = ad_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (capture) begin
            rdata_q <= cap_val;
        end
    end

    assign rdata = rdata_q;

endmodule
